a2d_arbiter: RTL and testbench
==============================

Name: a2d_arbiter

Overview:
Shares the single A2D interface (strt_cnv / chnnl / cnv_cmplt / 12-bit result) between three requesters: the motion controller's IR sampling, the battery monitor and the command/debug port. The arbiter picks requesters round-robin, drives the conversion and returns the result with a one-cycle done pulse. A watchdog aborts a conversion that never completes. It sits between the requesters and A2D_intf.

Parameters:
TIMEOUT_CYC, 4096, number of WAIT-state cycles without cnv_cmplt before the conversion is aborted (legal range 2..8191).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  arbitration enable; low blocks new grants only
req  input  3  request per requester; bit i = requester i; level, held until done[i] or err[i]
req_chnnl  input  9  requested channel; bits [3i+2:3i] belong to requester i
gnt  output  3  one-hot grant; high from START through RESP inclusive
done  output  3  one-cycle pulse to the granted requester when rd_data is valid
err  output  3  one-cycle pulse to the granted requester on timeout
rd_data  output  12  last captured conversion result; holds until the next capture
busy  output  1  high whenever state != IDLE
strt_cnv  output  1  one-cycle conversion start to A2D_intf
chnnl  output  3  channel to A2D_intf; registered, stable from START until the next grant
cnv_cmplt  input  1  conversion-complete level from A2D_intf
A2D_res  input  12  conversion result from A2D_intf

Behaviour:
- Reset values: gnt=0, done=0, err=0, rd_data=0, busy=0, strt_cnv=0, chnnl=0, state=IDLE, ptr=0, timeout counter=0. Reset is asynchronous and takes effect in any state, including mid-conversion. A conversion interrupted by reset is abandoned and no done/err pulse is issued.
- State machine has four states: IDLE, START, WAIT, RESP.
- IDLE:
  - If en=1 and req!=0, select a winner w and go to START.
  - On that same edge, register gnt=onehot(w) and chnnl=req_chnnl[3w+2:3w].
  - If en=0 or req=0, stay in IDLE.
- Round-robin selection: search order is ptr, ptr+1, ptr+2 (mod 3); the first requester with req set wins. On exit from RESP, ptr=(w+1) mod 3.
- START:
  - strt_cnv=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT.
  - cnv_cmplt is ignored in START and in IDLE, since a stale level from the previous conversion may still be high.
- WAIT:
  - If cnv_cmplt=1: capture rd_data<=A2D_res, set flag ok, go to RESP.
  - Else if counter==TIMEOUT_CYC-1: clear ok, go to RESP.
  - Else increment the counter.
  - If cnv_cmplt and the timeout coincide in the same cycle, cnv_cmplt wins.
- RESP:
  - done[w]=ok, err[w]=~ok, each for exactly one cycle. gnt stays high this cycle.
  - Go to IDLE; gnt clears on that edge.
  - On timeout, rd_data is not updated.
- Latency:
  - req rising in IDLE at cycle N gives gnt and chnnl valid at N+1 and strt_cnv at N+1.
  - cnv_cmplt seen in WAIT at cycle M gives done and rd_data valid at M+1.
  - Minimum requester-to-requester gap: one IDLE cycle after RESP.
- Requester rules:
  - A requester must drop req on the cycle after done/err unless it wants another conversion.
  - If req drops mid-conversion, the conversion still runs to completion and done/err still pulses.
  - req_chnnl is sampled only at grant.
- en deasserted during START/WAIT/RESP: the current conversion completes normally; no new grant is made until en=1.
- At most one bit of gnt, done or err is ever high. done and err are never high together.

Test Plan:
- Single request: req=3'b001, req_chnnl[2:0]=3'd3; model returns 12'h5A3 after 40 cycles.
  -> gnt=001 and chnnl=3 at N+1; one strt_cnv pulse at N+1; done=001 for one cycle; rd_data=12'h5A3; busy low after RESP.
- Fair arbitration: req=3'b111 held continuously from reset, each requester with a distinct channel.
  -> grant order 0,1,2,0,1,2; each strt_cnv carries the winner's chnnl; exactly one done per grant.
- Pointer update: after a grant to requester 2, present req=3'b011.
  -> next grant goes to 0, then to 1; after a grant to 0, with req=3'b110, the next grant goes to 1.
- Timeout: TIMEOUT_CYC=64, model never asserts cnv_cmplt.
  -> err[w] pulses exactly 64 WAIT cycles after START; no done pulse; rd_data unchanged; a pending request is granted afterwards.
- Coincidence and stale level:
  - Assert cnv_cmplt on the timeout cycle -> done pulses, err stays 0.
  - Hold cnv_cmplt high through IDLE and START -> it is not taken until WAIT.
- Reset and enable:
  - rst_n low in WAIT -> all outputs 0 immediately; no done/err pulse; ptr=0.
  - en=0 with req=3'b010 -> no strt_cnv.
  - en dropped during WAIT -> done still pulses and no further grant is made.

Source files
------------

// File: rtl/a2d_arbiter_if.sv
// Bundle of the requester-side and A2D_intf-side signals around the A2D arbiter.
// slave is the arbiter's view; master is the view of the requesters plus A2D_intf.
interface a2d_arbiter_if;
    logic        en;
    logic [2:0]  req;
    logic [8:0]  req_chnnl;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [11:0] rd_data;
    logic        busy;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;

    modport slave (
        input  en, req, req_chnnl, cnv_cmplt, A2D_res,
        output gnt, done, err, rd_data, busy, strt_cnv, chnnl
    );

    modport master (
        output en, req, req_chnnl, cnv_cmplt, A2D_res,
        input  gnt, done, err, rd_data, busy, strt_cnv, chnnl
    );
endinterface

// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D converter among three requesters, with a
// watchdog that aborts conversions that never report completion.
module a2d_arbiter #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    a2d_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [12:0] TMO_LAST = 13'(TIMEOUT_CYC - 1);

    logic [1:0]  state_reg;
    logic [1:0]  ptr_reg;
    logic [1:0]  win_reg;
    logic [12:0] tmo_cnt_reg;
    logic [2:0]  gnt_reg;
    logic [2:0]  done_reg;
    logic [2:0]  err_reg;
    logic [11:0] rd_data_reg;
    logic        strt_reg;
    logic [2:0]  chnnl_reg;

    logic [1:0]  cand [3];
    logic [2:0]  req_ch [3];
    logic [1:0]  pick;
    logic        pick_vld;

    // cand[k] is the requester examined k-th, starting from the pointer
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cand
            logic [2:0] sum;
            assign sum        = {1'b0, ptr_reg} + 3'(gi);
            assign cand[gi]   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            assign req_ch[gi] = bus.req_chnnl[3*gi+2 : 3*gi];
        end
    endgenerate

    // Scan from the far end so the earliest candidate in search order wins
    always_comb begin
        pick     = cand[0];
        pick_vld = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (bus.req[cand[k]]) begin
                pick     = cand[k];
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= 2'd0;
            win_reg     <= 2'd0;
            tmo_cnt_reg <= 13'd0;
            gnt_reg     <= 3'd0;
            done_reg    <= 3'd0;
            err_reg     <= 3'd0;
            rd_data_reg <= 12'd0;
            strt_reg    <= 1'b0;
            chnnl_reg   <= 3'd0;
        end else begin
            strt_reg <= 1'b0;
            done_reg <= 3'd0;
            err_reg  <= 3'd0;
            case (state_reg)
                IDLE: begin
                    if (bus.en && pick_vld) begin
                        state_reg <= START;
                        win_reg   <= pick;
                        gnt_reg   <= 3'b001 << pick;
                        chnnl_reg <= req_ch[pick];
                        strt_reg  <= 1'b1;
                    end
                end
                START: begin
                    // cnv_cmplt may still be high from the previous conversion
                    tmo_cnt_reg <= 13'd0;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    if (bus.cnv_cmplt) begin
                        rd_data_reg <= bus.A2D_res;
                        done_reg    <= gnt_reg;
                        state_reg   <= RESP;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        err_reg   <= gnt_reg;
                        state_reg <= RESP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 13'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= 3'd0;
                    ptr_reg   <= (win_reg == 2'd2) ? 2'd0 : win_reg + 2'd1;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_reg;
    assign bus.done     = done_reg;
    assign bus.err      = err_reg;
    assign bus.rd_data  = rd_data_reg;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.strt_cnv = strt_reg;
    assign bus.chnnl    = chnnl_reg;
endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed bench for a2d_arbiter: an A2D_intf model plus an expectation queue
// checked at every start pulse and every done/err pulse.
module tb_a2d_arbiter;
    logic clk;
    logic rst_n;
    a2d_arbiter_if bus ();

    a2d_arbiter #(.TIMEOUT_CYC(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0]  gnt;
        logic [2:0]  ch;
        logic        ok;
        logic [11:0] data;
        int          lat;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          strt_cyc = 0;
    int          n_strt = 0;
    logic        prev_strt = 1'b0;
    int          model_delay = -1;
    int          mcnt = -1;
    int          nconv = 0;
    int          exp_conv = 0;
    bit          stale_mode = 1'b0;
    logic [11:0] res_base = 12'h5A2;
    logic [11:0] last_data = 12'h000;
    int          s;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(int idx, logic [2:0] ch, logic ok, int lat);
        exp_t e;
        exp_conv++;
        e.gnt  = 3'b001 << idx;
        e.ch   = ch;
        e.ok   = ok;
        e.lat  = lat;
        e.data = ok ? 12'(res_base + 12'(exp_conv)) : last_data;
        if (ok) last_data = e.data;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.done | bus.err) == 3'd0 && n < 400);
        chk({tag, "_resp_seen"}, 32'((bus.done | bus.err) != 3'd0), 32'd1);
    endtask

    task automatic wait_strt(string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.strt_cnv && n < 50);
        chk({tag, "_strt_seen"}, 32'(bus.strt_cnv), 32'd1);
    endtask

    // A2D_intf model: cnv_cmplt is a level that rises model_delay cycles after start
    always @(negedge clk) begin
        if (stale_mode) begin
            bus.cnv_cmplt = 1'b1;
            if (bus.strt_cnv) begin
                nconv++;
                bus.A2D_res = 12'(res_base + 12'(nconv));
            end
        end else if (bus.strt_cnv) begin
            nconv++;
            bus.cnv_cmplt = 1'b0;
            mcnt = 0;
        end else if (model_delay > 0 && mcnt >= 0) begin
            mcnt++;
            if (mcnt == model_delay) begin
                bus.cnv_cmplt = 1'b1;
                bus.A2D_res   = 12'(res_base + 12'(nconv));
                mcnt = -1;
            end
        end
    end

    // Scoreboard: start pulses peek at the head, done/err pulses pop it
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strt = 1'b0;
        end else begin
            if (bus.strt_cnv) begin
                n_strt++;
                chk("strt_single", 32'(prev_strt), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("strt_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("strt_gnt", 32'(bus.gnt), 32'(exp_q[0].gnt));
                    chk("strt_chnnl", 32'(bus.chnnl), 32'(exp_q[0].ch));
                end
                strt_cyc = cyc;
            end
            if ((bus.done | bus.err) != 3'd0) begin
                if (exp_q.size() == 0) begin
                    chk("resp_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_done", 32'(bus.done), mon_e.ok ? 32'(mon_e.gnt) : 32'd0);
                    chk("resp_err", 32'(bus.err), mon_e.ok ? 32'd0 : 32'(mon_e.gnt));
                    chk("resp_gnt", 32'(bus.gnt), 32'(mon_e.gnt));
                    chk("resp_rd_data", 32'(bus.rd_data), 32'(mon_e.data));
                    chk("resp_latency", 32'(cyc - strt_cyc), 32'(mon_e.lat));
                    $display("[TB] resp gnt=%b done=%b err=%b rd_data=%h latency=%0d",
                             bus.gnt, bus.done, bus.err, bus.rd_data, cyc - strt_cyc);
                end
            end
            prev_strt = bus.strt_cnv;
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.en        = 1'b1;
        bus.req       = 3'b000;
        bus.req_chnnl = 9'd0;
        bus.cnv_cmplt = 1'b0;
        bus.A2D_res   = 12'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_strt", 32'(bus.strt_cnv), 32'd0);
        chk("rst_chnnl", 32'(bus.chnnl), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request on channel 3, result 5A3 after 40 cycles
        model_delay = 40;
        bus.req_chnnl = 9'd3;
        push_exp(0, 3'd3, 1'b1, 41);
        bus.req = 3'b001;
        @(negedge clk);
        chk("single_strt", 32'(bus.strt_cnv), 32'd1);
        chk("single_gnt", 32'(bus.gnt), 32'b001);
        chk("single_chnnl", 32'(bus.chnnl), 32'd3);
        chk("single_busy", 32'(bus.busy), 32'd1);
        wait_resp("single");
        bus.req = 3'b000;
        chk("single_data", 32'(bus.rd_data), 32'h5A3);
        @(negedge clk);
        chk("single_idle_busy", 32'(bus.busy), 32'd0);
        chk("single_idle_gnt", 32'(bus.gnt), 32'd0);

        // Fairness: all three requesting from reset
        rst_n = 1'b0;
        last_data = 12'd0;
        bus.req = 3'b111;
        bus.req_chnnl = {3'd7, 3'd6, 3'd5};
        model_delay = 3;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) push_exp(k % 3, 3'(5 + k % 3), 1'b1, 4);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) wait_resp("fair");
        bus.req = 3'b000;
        @(negedge clk);

        // Pointer: after 2, req=011 -> 0 then 1; then 0 alone; then 110 -> 1
        push_exp(0, 3'd5, 1'b1, 4);
        push_exp(1, 3'd6, 1'b1, 4);
        bus.req = 3'b011;
        wait_resp("ptr_a");
        bus.req = bus.req & ~(bus.done | bus.err);
        wait_resp("ptr_b");
        bus.req = 3'b000;
        push_exp(0, 3'd5, 1'b1, 4);
        bus.req = 3'b001;
        wait_resp("ptr_c");
        bus.req = 3'b000;
        push_exp(1, 3'd6, 1'b1, 4);
        bus.req = 3'b110;
        wait_resp("ptr_d");
        bus.req = 3'b000;

        // Timeout on requester 2, then a pending request from 0 is served
        model_delay = -1;
        push_exp(2, 3'd7, 1'b0, 65);
        bus.req = 3'b100;
        wait_resp("tmo");
        model_delay = 5;
        push_exp(0, 3'd5, 1'b1, 6);
        bus.req = 3'b001;
        wait_resp("tmo_next");
        bus.req = 3'b000;

        // cnv_cmplt on the final timeout cycle wins
        model_delay = 64;
        push_exp(1, 3'd6, 1'b1, 65);
        bus.req = 3'b010;
        wait_resp("coinc");
        bus.req = 3'b000;

        // Stale cnv_cmplt held high through IDLE and START
        stale_mode = 1'b1;
        repeat (3) @(negedge clk);
        chk("stale_idle_busy", 32'(bus.busy), 32'd0);
        push_exp(2, 3'd7, 1'b1, 2);
        bus.req = 3'b100;
        wait_resp("stale");
        bus.req = 3'b000;
        stale_mode = 1'b0;
        @(negedge clk);

        // Reset in WAIT clears everything, then pointer restarts at 0
        model_delay = -1;
        push_exp(1, 3'd6, 1'b0, 0);
        bus.req = 3'b010;
        wait_strt("rstw");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstw_gnt", 32'(bus.gnt), 32'd0);
        chk("rstw_busy", 32'(bus.busy), 32'd0);
        chk("rstw_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rstw_chnnl", 32'(bus.chnnl), 32'd0);
        chk("rstw_done_err", 32'(bus.done | bus.err), 32'd0);
        exp_q.delete();
        last_data = 12'd0;
        bus.req = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        model_delay = 5;
        push_exp(0, 3'd5, 1'b1, 6);
        bus.req = 3'b111;
        wait_resp("rstw_ptr");
        bus.req = 3'b000;

        // en low blocks new grants
        s = n_strt;
        bus.en = 1'b0;
        bus.req = 3'b010;
        repeat (20) @(negedge clk);
        chk("en_low_no_strt", 32'(n_strt - s), 32'd0);
        chk("en_low_busy", 32'(bus.busy), 32'd0);
        bus.req = 3'b000;
        bus.en = 1'b1;
        @(negedge clk);

        // en dropped during WAIT: current conversion completes, no new grant
        model_delay = 10;
        push_exp(1, 3'd6, 1'b1, 11);
        bus.req = 3'b011;
        wait_strt("endrop");
        repeat (2) @(negedge clk);
        bus.en = 1'b0;
        wait_resp("endrop");
        bus.req = 3'b001;
        s = n_strt;
        repeat (20) @(negedge clk);
        chk("endrop_no_strt", 32'(n_strt - s), 32'd0);
        chk("endrop_busy", 32'(bus.busy), 32'd0);
        push_exp(0, 3'd5, 1'b1, 11);
        bus.en = 1'b1;
        wait_resp("endrop_resume");
        bus.req = 3'b000;
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
